// File: rtl/stats_uart_tx.sv
// stats_uart_tx: serialises a snapshot of the pet's five 5-bit stats and its sleep flag
// into a fixed 8N1, LSB-first UART status frame on a single TX pin.
//
// Frame: A5 (sync), hunger, happiness, hygiene, energy, social, sleep flag
//        [, XOR checksum of bytes 1..6 when STATS_UART_TX_CHECKSUM_EN is defined]
//
// Ports:
//   i_clk         system clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   i_send        frame request, honoured only while idle
//   i_hunger, i_happiness, i_hygiene, i_energy, i_social   5-bit live stats
//   i_is_sleeping live sleep flag
//   o_uart_tx     serial line, idles high, driven straight from a flop
//   o_busy        high while a frame is being sent
//   o_done        one-cycle pulse when the frame completes
//
// Optional feature macro: STATS_UART_TX_CHECKSUM_EN (adds the checksum byte).

module stats_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 87
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_send,
    input  logic [4:0] i_hunger,
    input  logic [4:0] i_happiness,
    input  logic [4:0] i_hygiene,
    input  logic [4:0] i_energy,
    input  logic [4:0] i_social,
    input  logic       i_is_sleeping,
    output logic       o_uart_tx,
    output logic       o_busy,
    output logic       o_done
);

`ifdef STATS_UART_TX_CHECKSUM_EN
    localparam int unsigned NBYTES = 8;
`else
    localparam int unsigned NBYTES = 7;
`endif

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  LAST_BYTE = 3'(NBYTES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    state_e      r_state;
    logic [15:0] r_baud;
    logic [2:0]  r_bit;
    logic [2:0]  r_byte;
    logic [7:0]  r_shift;
    logic [4:0]  r_hunger, r_happiness, r_hygiene, r_energy, r_social;
    logic        r_sleep;
    logic        r_tx, r_busy, r_done;

    state_e      w_state_d;
    logic [15:0] w_baud_d;
    logic [2:0]  w_bit_d;
    logic [2:0]  w_byte_d;
    logic [7:0]  w_shift_d;
    logic        w_tx_d, w_busy_d, w_done_d;
    logic        w_accept;
    logic        w_baud_end;
    logic [7:0]  w_byte_val;

    assign w_accept   = (r_state == StIdle) && i_send;
    assign w_baud_end = (r_baud == BAUD_LAST);

`ifdef STATS_UART_TX_CHECKSUM_EN
    logic [7:0] w_checksum;
    assign w_checksum = {3'b000, r_hunger} ^ {3'b000, r_happiness} ^ {3'b000, r_hygiene} ^
                        {3'b000, r_energy} ^ {3'b000, r_social} ^ {7'b0, r_sleep};
`endif

    // Byte of the frame selected by the byte index, built from the snapshot.
    always_comb begin
        w_byte_val = 8'h00;
        case (r_byte)
            3'd0: w_byte_val = 8'hA5;
            3'd1: w_byte_val = {3'b000, r_hunger};
            3'd2: w_byte_val = {3'b000, r_happiness};
            3'd3: w_byte_val = {3'b000, r_hygiene};
            3'd4: w_byte_val = {3'b000, r_energy};
            3'd5: w_byte_val = {3'b000, r_social};
            3'd6: w_byte_val = {7'b0, r_sleep};
`ifdef STATS_UART_TX_CHECKSUM_EN
            3'd7: w_byte_val = w_checksum;
`endif
            default: w_byte_val = 8'h00;
        endcase
    end

    // Next state plus next-cycle outputs; outputs are registered from the next state so the
    // line changes on the same edge the state does.
    always_comb begin
        w_state_d = r_state;
        w_baud_d  = r_baud;
        w_bit_d   = r_bit;
        w_byte_d  = r_byte;
        w_shift_d = r_shift;
        w_done_d  = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (i_send) begin
                    w_state_d = StStart;
                    w_baud_d  = '0;
                    w_byte_d  = '0;
                end
            end
            StStart: begin
                if (w_baud_end) begin
                    w_state_d = StData;
                    w_baud_d  = '0;
                    w_bit_d   = '0;
                    w_shift_d = w_byte_val;
                end else begin
                    w_baud_d = r_baud + 16'd1;
                end
            end
            StData: begin
                if (w_baud_end) begin
                    w_baud_d = '0;
                    if (r_bit == 3'd7) begin
                        w_state_d = StStop;
                    end else begin
                        w_bit_d   = r_bit + 3'd1;
                        w_shift_d = {1'b0, r_shift[7:1]};
                    end
                end else begin
                    w_baud_d = r_baud + 16'd1;
                end
            end
            StStop: begin
                if (w_baud_end) begin
                    w_baud_d = '0;
                    if (r_byte == LAST_BYTE) begin
                        w_state_d = StIdle;
                        w_done_d  = 1'b1;
                    end else begin
                        w_byte_d  = r_byte + 3'd1;
                        w_state_d = StStart;
                    end
                end else begin
                    w_baud_d = r_baud + 16'd1;
                end
            end
        endcase

        w_busy_d = (w_state_d != StIdle);
        w_tx_d   = 1'b1;
        if (w_state_d == StStart) begin
            w_tx_d = 1'b0;
        end else if (w_state_d == StData) begin
            w_tx_d = w_shift_d[0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_baud  <= '0;
            r_bit   <= '0;
            r_byte  <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_baud  <= w_baud_d;
            r_bit   <= w_bit_d;
            r_byte  <= w_byte_d;
            r_shift <= w_shift_d;
            r_tx    <= w_tx_d;
            r_busy  <= w_busy_d;
            r_done  <= w_done_d;
        end
    end

    // Snapshot of the live inputs, taken only when a request is accepted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hunger    <= '0;
            r_happiness <= '0;
            r_hygiene   <= '0;
            r_energy    <= '0;
            r_social    <= '0;
            r_sleep     <= 1'b0;
        end else if (w_accept) begin
            r_hunger    <= i_hunger;
            r_happiness <= i_happiness;
            r_hygiene   <= i_hygiene;
            r_energy    <= i_energy;
            r_social    <= i_social;
            r_sleep     <= i_is_sleeping;
        end
    end

    assign o_uart_tx = r_tx;
    assign o_busy    = r_busy;
    assign o_done    = r_done;

endmodule

// File: tb/tb_stats_uart_tx.sv
// Directed bench for stats_uart_tx: a fast instance (4 clocks/bit) for frame content and
// control behaviour, and a default-rate instance (87 clocks/bit) for bit timing.
module tb_stats_uart_tx;

`ifdef STATS_UART_TX_CHECKSUM_EN
    localparam int NBYTES = 8;
`else
    localparam int NBYTES = 7;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       send4 = 1'b0;
    logic       send87 = 1'b0;
    logic [4:0] hunger, happiness, hygiene, energy, social;
    logic       is_sleeping;
    logic       tx4, busy4, done4;
    logic       tx87, busy87, done87;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] exp_bytes [8] = '{8'hA5, 8'h11, 8'h1F, 8'h00, 8'h0A, 8'h03, 8'h01, 8'h06};

    always #5 clk = ~clk;

    stats_uart_tx #(.CLKS_PER_BIT(4)) u_dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_send       (send4),
        .i_hunger     (hunger),
        .i_happiness  (happiness),
        .i_hygiene    (hygiene),
        .i_energy     (energy),
        .i_social     (social),
        .i_is_sleeping(is_sleeping),
        .o_uart_tx    (tx4),
        .o_busy       (busy4),
        .o_done       (done4)
    );

    stats_uart_tx #(.CLKS_PER_BIT(87)) u_dut87 (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_send       (send87),
        .i_hunger     (hunger),
        .i_happiness  (happiness),
        .i_hygiene    (hygiene),
        .i_energy     (energy),
        .i_social     (social),
        .i_is_sleeping(is_sleeping),
        .o_uart_tx    (tx87),
        .o_busy       (busy87),
        .o_done       (done87)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_golden();
        hunger = 5'd17; happiness = 5'd31; hygiene = 5'd0;
        energy = 5'd10; social = 5'd3; is_sleeping = 1'b1;
    endtask

    task automatic set_send(input bit sel, input logic v);
        if (sel) send87 = v;
        else     send4 = v;
    endtask

    // One-cycle request sampled on the second posedge; returns #1 after that edge.
    task automatic send_pulse(input bit sel);
        @(posedge clk); #1 set_send(sel, 1'b1);
        @(posedge clk); #1 set_send(sel, 1'b0);
    endtask

    // Called just after the edge that accepted a request: the first negedge is t=0, the
    // first cycle of the start bit. Decodes the frame at bit centres and checks timing.
    task automatic run_frame(input bit sel, input int zero_at, input int poke_a,
                             input int poke_b, input bit send_in_done, input string tag);
        int p, f, b, j, ph, busy_cnt, done_cnt, bad_edge, frame_err;
        logic tx_v, busy_v, done_v, prev;
        logic [7:0] rx [8];
        p = sel ? 87 : 4;
        f = 10 * p * NBYTES;
        busy_cnt = 0; done_cnt = 0; bad_edge = 0; frame_err = 0; prev = 1'b1;
        for (int k = 0; k < 8; k++) rx[k] = 8'h00;
        for (int t = 0; t <= f; t++) begin
            @(negedge clk);
            tx_v   = sel ? tx87 : tx4;
            busy_v = sel ? busy87 : busy4;
            done_v = sel ? done87 : done4;
            if (t == zero_at) begin
                hunger = '0; happiness = '0; hygiene = '0; energy = '0; social = '0;
                is_sleeping = 1'b0;
            end
            if (t < f) set_send(sel, (t == poke_a) || (t == poke_b));
            if (t == 0) begin
                check_eq({tag, "_start_tx"}, 32'(tx_v), 32'd0);
                check_eq({tag, "_start_busy"}, 32'(busy_v), 32'd1);
            end
            if (t < f) begin
                busy_cnt += int'(busy_v);
                done_cnt += int'(done_v);
                if (tx_v !== prev && (t % p) != 0) bad_edge++;
                prev = tx_v;
                b  = t / (10 * p);
                j  = (t % (10 * p)) / p;
                ph = t % p;
                if (ph == p / 2) begin
                    if (j == 0) begin
                        if (tx_v !== 1'b0) frame_err++;
                    end else if (j == 9) begin
                        if (tx_v !== 1'b1) frame_err++;
                    end else begin
                        rx[b][j-1] = tx_v;
                    end
                end
            end else begin
                check_eq({tag, "_end_busy"}, 32'(busy_v), 32'd0);
                check_eq({tag, "_end_done"}, 32'(done_v), 32'd1);
                set_send(sel, send_in_done);
            end
        end
        for (int k = 0; k < NBYTES; k++) begin
            check_eq($sformatf("%s_byte%0d", tag, k), 32'(rx[k]), 32'(exp_bytes[k]));
        end
        check_eq({tag, "_framing"}, 32'(frame_err), 32'd0);
        check_eq({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(f));
        check_eq({tag, "_early_done"}, 32'(done_cnt), 32'd0);
        check_eq({tag, "_bit_edges"}, 32'(bad_edge), 32'd0);
        if (!send_in_done) begin
            @(negedge clk);
            tx_v   = sel ? tx87 : tx4;
            busy_v = sel ? busy87 : busy4;
            done_v = sel ? done87 : done4;
            check_eq({tag, "_post_done"}, 32'(done_v), 32'd0);
            check_eq({tag, "_post_busy"}, 32'(busy_v), 32'd0);
            check_eq({tag, "_post_tx"}, 32'(tx_v), 32'd1);
        end
    endtask

    initial begin
        int bad;
        set_golden();

        // Reset and idle behaviour.
        repeat (5) @(negedge clk);
        check_eq("rst_tx", 32'(tx4), 32'd1);
        check_eq("rst_busy", 32'(busy4), 32'd0);
        check_eq("rst_done", 32'(done4), 32'd0);
        check_eq("rst_tx87", 32'(tx87), 32'd1);
        rst_n = 1'b1;
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (tx4 !== 1'b1 || busy4 !== 1'b0 || done4 !== 1'b0) bad++;
            if (tx87 !== 1'b1 || busy87 !== 1'b0 || done87 !== 1'b0) bad++;
        end
        check_eq("idle_1000", 32'(bad), 32'd0);

        // Golden frame.
        send_pulse(1'b0);
        run_frame(1'b0, -1, -1, -1, 1'b0, "golden");

        // Inputs zeroed mid-frame must not disturb the snapshot.
        set_golden();
        send_pulse(1'b0);
        run_frame(1'b0, 50, -1, -1, 1'b0, "snap");
        set_golden();

        // Requests while busy are dropped, not queued.
        send_pulse(1'b0);
        run_frame(1'b0, -1, 10, 100, 1'b0, "ignore");
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy4 !== 1'b0 || tx4 !== 1'b1 || done4 !== 1'b0) bad++;
        end
        check_eq("ignore_no_second", 32'(bad), 32'd0);

        // Request during the done cycle starts the next frame right away.
        send_pulse(1'b0);
        run_frame(1'b0, -1, -1, -1, 1'b1, "b2b_a");
        @(posedge clk); #1 send4 = 1'b0;
        run_frame(1'b0, -1, -1, -1, 1'b0, "b2b_b");

        // Reset during the data bits of byte 3.
        send_pulse(1'b0);
        repeat (132) @(negedge clk);
        check_eq("mid_pre_busy", 32'(busy4), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_tx", 32'(tx4), 32'd1);
        check_eq("mid_rst_busy", 32'(busy4), 32'd0);
        check_eq("mid_rst_done", 32'(done4), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (400) begin
            @(negedge clk);
            if (busy4 !== 1'b0 || tx4 !== 1'b1 || done4 !== 1'b0) bad++;
        end
        check_eq("mid_rst_quiet", 32'(bad), 32'd0);
        send_pulse(1'b0);
        run_frame(1'b0, -1, -1, -1, 1'b0, "after_rst");

        // Default bit rate: every transition on a multiple of 87 cycles.
        send_pulse(1'b1);
        run_frame(1'b1, -1, -1, -1, 1'b0, "baud87");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stats_uart_tx.md
# stats_uart_tx

Serializes a snapshot of the pet's five 5-bit stats and its sleep flag into a fixed UART status frame on a single TX pin. It is the transmit half of the tamagotchi's serial link. It is triggered by a one-cycle request, typically the one-second tick. Frames are 8N1, LSB first, and are decoded by the host-side receiver.

## Interface
- CLKS_PER_BIT, default 87 — clock cycles per UART bit (10 MHz / 115200 baud); legal range 2..65535.
- clk  in  1  — single system clock; all logic rising-edge.
- rst_n  in  1  — asynchronous, active-low reset.
- send  in  1  — frame request; sampled each cycle, honoured only in IDLE.
- hunger, happiness, hygiene, energy, social  in  5 each  — live stat values.
- is_sleeping  in  1  — live sleep flag.
- uart_tx  out  1  — serial line; idles high.
- busy  out  1  — high from the cycle after an accepted send until the frame completes.
- done  out  1  — one-cycle pulse when the frame completes.

## Operation
- Frame byte order:
  - B0 = 8'hA5 (sync).
  - B1..B5 = {3'b000, stat} in the order hunger, happiness, hygiene, energy, social.
  - B6 = {7'b0, is_sleeping}.
  - B7 = checksum (see Configuration).
- Snapshot: all six inputs are latched in the cycle send is accepted. Input changes during a frame do not affect it.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: uart_tx=1, busy=0. If send=1, latch the snapshot, byte_idx=0, go to START.
  - START: uart_tx=0 for CLKS_PER_BIT cycles, load shift register with byte[byte_idx], go to DATA.
  - DATA: output shift[0] for CLKS_PER_BIT cycles per bit, 8 bits, LSB first, then go to STOP.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles. If byte_idx < NBYTES-1: increment byte_idx, go to START with no idle gap. Otherwise go to IDLE and pulse done.
- Counters:
  - Baud counter: 16 bits, counts 0..CLKS_PER_BIT-1, cleared on each state or bit change.
  - Bit counter: 3 bits.
  - Byte index: 3 bits.
- send while busy is ignored. Requests are not queued.
- send asserted in the done cycle (state already IDLE) is accepted.
- Reset mid-frame: uart_tx goes high and busy/done go low immediately (asynchronously). The snapshot and counters are discarded. The next frame starts only on a new send after reset release.

## Timing
- Reset values: uart_tx=1, busy=0, done=0, state=IDLE.
- send high at edge N: at edge N+1, uart_tx=0 (start bit) and busy=1.
- Each bit occupies exactly CLKS_PER_BIT cycles. Each byte occupies 10*CLKS_PER_BIT cycles.
- Frame length is 10*CLKS_PER_BIT*NBYTES cycles; NBYTES=8 with checksum, 7 without.
- After the final stop-bit cycle, the next edge gives busy=0 and done=1 for exactly one cycle.
- uart_tx is driven directly from a register (glitch-free).

## Configuration
- STATS_UART_TX_CHECKSUM_EN defined:
  - NBYTES=8.
  - B7 = XOR of B1..B6 (sync byte excluded).
- Not defined:
  - NBYTES=7; the frame ends after B6.
  - No checksum logic is synthesized.

## Test plan
- Reset/idle: hold rst_n=0, then release with no send → uart_tx=1, busy=0, done=0 for 1000 cycles.
- Golden frame (CLKS_PER_BIT=4, macro on): set hunger=17, happiness=31, hygiene=0, energy=10, social=3, is_sleeping=1, pulse send.
  - Decoded bytes must be A5 11 1F 00 0A 03 01 06.
  - busy high for 320 cycles; done pulses once.
  - With the macro off: A5 11 1F 00 0A 03 01, 280 cycles.
- Snapshot: change all stats to 0 at cycle 50 of the golden frame → decoded bytes unchanged from the golden frame.
- Busy ignore / back-to-back:
  - Pulse send at cycles 10 and 100 of a frame → exactly one frame, one done.
  - Pulse send in the done cycle → start bit begins on the next cycle.
- Reset mid-frame: assert rst_n=0 during the DATA bits of B3 → uart_tx=1 and busy=0 within the same cycle, and no done pulse. After release plus a new send, a complete correct frame is sent.
- Bit timing: CLKS_PER_BIT=87 → every line transition falls on a multiple of 87 cycles from the start-bit edge (±0), across all 80 bits.
